// File: rtl/sr_latch_bank_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sr_latch_pkg
// Shared definitions for the SR latch bank controller:
//   srlb_state_t : sequencer state encoding (IDLE, SETUP, GATE, RELEASE)
//   OP_SET/OP_CLR: request opcode values (1 = drive q to 1, 0 = drive q to 0)
//   gate_cnt_w() : width of the counter that times the GATE phase
// ----------------------------------------------------------------------------
package sr_latch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        GATE    = 2'd2,
        RELEASE = 2'd3
    } srlb_state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // The counter runs 0 .. cyc-1, so it needs at least one bit even for cyc <= 2.
    function automatic int gate_cnt_w(input int cyc);
        if (cyc <= 2) begin
            return 1;
        end else begin
            return $clog2(cyc);
        end
    endfunction

endpackage

// File: rtl/sr_latch_bank_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at 'ptr' and
// wraps, so the first requester at or after the pointer wins. The pointer
// register itself belongs to the parent.
// Ports:
//   req     in  N    request vector
//   ptr     in  PW   search start position
//   gnt     out N    one-hot grant (all-zero when no request)
//   gnt_idx out PW   binary index of the granted requester
//   any_gnt out 1    at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any_gnt
);

    int pos_s;

    // Rotating priority search starting at the pointer.
    always_comb begin
        gnt     = {N{1'b0}};
        gnt_idx = {PW{1'b0}};
        any_gnt = 1'b0;
        pos_s   = 0;
        for (int k = 0; k < N; k++) begin
            pos_s = (int'(ptr) + k) % N;
            if (!any_gnt && req[pos_s]) begin
                any_gnt    = 1'b1;
                gnt[pos_s] = 1'b1;
                gnt_idx    = pos_s[PW-1:0];
            end else begin
                any_gnt = any_gnt;
            end
        end
    end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// ----------------------------------------------------------------------------
// sr_latch_bank_ctrl
// Sequencer/arbiter for a bank of NLAT gated SR latches sharing one set line,
// one clear line and a per-latch gate. Requesters are served round-robin, one
// at a time, with a setup -> gate -> release sequence per operation. Set and
// clear are never driven together and the gate only opens while data is stable.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset (aborts any operation)
//   req_valid  in   NREQ       per-requester request, held until its req_done
//   req_op     in   NREQ       per-requester op (1 = set, 0 = clear)
//   req_idx    in   NREQ*IDXW  per-requester latch index, slice i = [i*IDXW +: IDXW]
//   req_done   out  NREQ       one-cycle completion pulse to the granted requester
//   idx_err    out  1          pulses with req_done when the captured idx >= NLAT
//   lat_set    out  1          shared set drive
//   lat_clr    out  1          shared clear drive
//   lat_gate   out  NLAT       one-hot gate enable, only during GATE
//   busy       out  1          sequencer not in IDLE
//   shadow_q   out  NLAT       mirror of the latch contents
//
// Build option: define SRLB_SHADOW_EN to keep a shadow copy of the latch bank;
// without it shadow_q is constant zero and no shadow flops exist.
// All outputs are registered; they are computed from the next state so they
// line up exactly with the state they belong to.
// ----------------------------------------------------------------------------
module sr_latch_bank_ctrl
    import sr_latch_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int NLAT     = 8,
    parameter  int GATE_CYC = 2,
    localparam int IDXW     = $clog2(NLAT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_done,
    output logic                 idx_err,
    output logic                 lat_set,
    output logic                 lat_clr,
    output logic [NLAT-1:0]      lat_gate,
    output logic                 busy,
    output logic [NLAT-1:0]      shadow_q
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = gate_cnt_w(GATE_CYC);

    localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [IDXW:0]   NLAT_LIM = (IDXW + 1)'(NLAT);

    generate
        if (GATE_CYC < 1) begin : g_bad_gate_cyc
            $error("sr_latch_bank_ctrl: GATE_CYC must be >= 1");
        end
        if (NREQ < 2) begin : g_bad_nreq
            $error("sr_latch_bank_ctrl: NREQ must be >= 2");
        end
        if (NLAT < 2) begin : g_bad_nlat
            $error("sr_latch_bank_ctrl: NLAT must be >= 2");
        end
    endgenerate

    srlb_state_t     state_r,   state_nxt_s;
    logic [PW-1:0]   ptr_r,     ptr_nxt_s;
    logic [PW-1:0]   win_r,     win_nxt_s;
    logic            op_r,      op_nxt_s;
    logic [IDXW-1:0] idx_r,     idx_nxt_s;
    logic [CW-1:0]   cnt_r,     cnt_nxt_s;

    logic [NREQ-1:0] gnt_s;
    logic [PW-1:0]   gnt_idx_s;
    logic            any_gnt_s;
    logic            sel_op_s;
    logic [IDXW-1:0] sel_idx_s;

    logic            set_nxt_s,  set_r;
    logic            clr_nxt_s,  clr_r;
    logic            busy_nxt_s, busy_r;
    logic            err_nxt_s,  err_r;
    logic [NLAT-1:0] gate_nxt_s, gate_r;
    logic [NREQ-1:0] done_nxt_s, done_r;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any_gnt (any_gnt_s)
    );

    // Payload of the current arbitration winner; only used at grant time.
    assign sel_op_s  = req_op[gnt_idx_s];
    assign sel_idx_s = req_idx[gnt_idx_s * IDXW +: IDXW];

    // Next-state and payload capture for the setup/gate/release sequence.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        win_nxt_s   = win_r;
        op_nxt_s    = op_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (any_gnt_s) begin
                    state_nxt_s = SETUP;
                    win_nxt_s   = gnt_idx_s;
                    op_nxt_s    = sel_op_s;
                    idx_nxt_s   = sel_idx_s;
                    cnt_nxt_s   = {CW{1'b0}};
                    ptr_nxt_s   = (gnt_idx_s == PTR_LAST) ? {PW{1'b0}} : gnt_idx_s + PTR_ONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = GATE;
                cnt_nxt_s   = {CW{1'b0}};
            end
            GATE: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = RELEASE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            RELEASE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values belonging to the next state; set and clear are mutually
    // exclusive by construction since both derive from the single op bit.
    always_comb begin
        busy_nxt_s = (state_nxt_s != IDLE);
        set_nxt_s  = (state_nxt_s != IDLE) && (op_nxt_s == OP_SET);
        clr_nxt_s  = (state_nxt_s != IDLE) && (op_nxt_s == OP_CLR);
        err_nxt_s  = (state_nxt_s == RELEASE) && ({1'b0, idx_nxt_s} >= NLAT_LIM);
        gate_nxt_s = {NLAT{1'b0}};
        done_nxt_s = {NREQ{1'b0}};
        // An out-of-range index matches no gate bit, so the gate stays closed.
        for (int i = 0; i < NLAT; i++) begin
            gate_nxt_s[i] = (state_nxt_s == GATE) && (idx_nxt_s == i[IDXW-1:0]);
        end
        for (int i = 0; i < NREQ; i++) begin
            done_nxt_s[i] = (state_nxt_s == RELEASE) && (win_nxt_s == i[PW-1:0]);
        end
    end

    // State, pointer, captured payload and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= {PW{1'b0}};
            win_r   <= {PW{1'b0}};
            op_r    <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            set_r   <= 1'b0;
            clr_r   <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            gate_r  <= {NLAT{1'b0}};
            done_r  <= {NREQ{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            win_r   <= win_nxt_s;
            op_r    <= op_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            set_r   <= set_nxt_s;
            clr_r   <= clr_nxt_s;
            busy_r  <= busy_nxt_s;
            err_r   <= err_nxt_s;
            gate_r  <= gate_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign req_done = done_r;
    assign idx_err  = err_r;
    assign lat_set  = set_r;
    assign lat_clr  = clr_r;
    assign lat_gate = gate_r;
    assign busy     = busy_r;

`ifdef SRLB_SHADOW_EN
    logic [NLAT-1:0] shadow_r;
    logic [NLAT-1:0] shadow_nxt_s;

    // Shadow copy follows the bank as the operation enters RELEASE.
    always_comb begin
        shadow_nxt_s = shadow_r;
        for (int i = 0; i < NLAT; i++) begin
            if ((state_nxt_s == RELEASE) && (idx_nxt_s == i[IDXW-1:0])) begin
                shadow_nxt_s[i] = op_nxt_s;
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= {NLAT{1'b0}};
        end else begin
            shadow_r <= shadow_nxt_s;
        end
    end

    assign shadow_q = shadow_r;
`else
    assign shadow_q = {NLAT{1'b0}};
`endif

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sr_latch_bank_ctrl
// Directed bench for sr_latch_bank_ctrl (NREQ=4, NLAT=6, GATE_CYC=2). The
// stimulus pushes the expected completion of each operation into a queue; a
// monitor pops an entry whenever req_done pulses and compares it, while also
// watching the set/clear exclusivity and gate one-hot properties every cycle.
// ----------------------------------------------------------------------------
module tb_sr_latch_bank_ctrl;

    localparam int NREQ     = 4;
    localparam int NLAT     = 6;
    localparam int GATE_CYC = 2;
    localparam int IDXW     = 3;

`ifdef SRLB_SHADOW_EN
    localparam bit SHADOW_ON = 1'b1;
`else
    localparam bit SHADOW_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_op;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      req_done;
    logic                 idx_err;
    logic                 lat_set;
    logic                 lat_clr;
    logic [NLAT-1:0]      lat_gate;
    logic                 busy;
    logic [NLAT-1:0]      shadow_q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [NREQ-1:0] done;
        logic            err;
        int              gcnt;
        logic [NLAT-1:0] gval;
        logic            op;
        logic [NLAT-1:0] sh;
        int              cyc;
    } exp_t;

    exp_t            exp_q[$];
    logic [NLAT-1:0] sh_model = 6'b000000;
    int              g_cnt = 0;
    logic [NLAT-1:0] g_or  = 6'b000000;
    exp_t            cur_e;

    sr_latch_bank_ctrl #(
        .NREQ     (NREQ),
        .NLAT     (NLAT),
        .GATE_CYC (GATE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_done  (req_done),
        .idx_err   (idx_err),
        .lat_set   (lat_set),
        .lat_clr   (lat_clr),
        .lat_gate  (lat_gate),
        .busy      (busy),
        .shadow_q  (shadow_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record the expected completion of one operation; done expected at cycle ecyc.
    task automatic push_exp(input int r, input bit op, input int idx, input int ecyc);
        exp_t e;
        e.done = 4'b0001 << r;
        e.err  = (idx >= NLAT);
        e.gcnt = (idx < NLAT) ? GATE_CYC : 0;
        e.gval = (idx < NLAT) ? (6'b000001 << idx) : 6'b000000;
        if (SHADOW_ON && (idx < NLAT)) sh_model[idx] = op;
        e.op   = op;
        e.sh   = sh_model;
        e.cyc  = ecyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_done(input int r);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_done[r] == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", {31'd0, req_done[r]}, 32'd1);
    endtask

    task automatic drive(input int r, input bit op, input int idx);
        logic [31:0] iv;
        iv = idx;
        req_op[r]              = op;
        req_idx[r*IDXW +: IDXW] = iv[IDXW-1:0];
        req_valid[r]           = 1'b1;
    endtask

    task automatic single_op(input int r, input bit op, input int idx);
        wait_idle();
        drive(r, op, idx);
        push_exp(r, op, idx, cyc + 4);
        wait_done(r);
        req_valid[r] = 1'b0;
    endtask

    // Monitor: per-cycle invariants plus scoreboard compare on each done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                g_cnt = 0;
                g_or  = 6'b000000;
            end else begin
                chk("set_clr_excl", {31'd0, lat_set & lat_clr}, 32'd0);
                chk("gate_onehot0", {31'd0, $onehot0(lat_gate)}, 32'd1);
                if (lat_gate != 6'b000000) begin
                    g_cnt++;
                    g_or = g_or | lat_gate;
                end
                if (idx_err && (req_done == 4'b0000)) chk("err_without_done", {31'd0, idx_err}, 32'd0);
                if (req_done != 4'b0000) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", {28'd0, req_done}, 32'd0);
                    end else begin
                        cur_e = exp_q.pop_front();
                        chk("done_vec",       {28'd0, req_done}, {28'd0, cur_e.done});
                        chk("idx_err",        {31'd0, idx_err},  {31'd0, cur_e.err});
                        chk("gate_cycles",    g_cnt,             cur_e.gcnt);
                        chk("gate_pattern",   {26'd0, g_or},     {26'd0, cur_e.gval});
                        chk("set_at_release", {31'd0, lat_set},  {31'd0, cur_e.op});
                        chk("clr_at_release", {31'd0, lat_clr},  {31'd0, ~cur_e.op});
                        chk("shadow",         {26'd0, shadow_q}, {26'd0, cur_e.sh});
                        chk("done_cycle",     cyc,               cur_e.cyc);
                    end
                    g_cnt = 0;
                    g_or  = 6'b000000;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every requester active; payloads for the round-robin run.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_op    = 4'b1101;
        req_idx   = {3'd4, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_done",  {28'd0, req_done}, 32'd0);
            chk("rst_busy",  {31'd0, busy},     32'd0);
            chk("rst_set",   {31'd0, lat_set},  32'd0);
            chk("rst_clr",   {31'd0, lat_clr},  32'd0);
            chk("rst_gate",  {26'd0, lat_gate}, 32'd0);
            chk("rst_err",   {31'd0, idx_err},  32'd0);
            chk("rst_shadow",{26'd0, shadow_q}, 32'd0);
        end
        rst = 1'b0;

        // Continuous requests: grant order 0,1,2,3,0, one operation per 5 cycles.
        push_exp(0, 1'b1, 0, cyc + 4);
        push_exp(1, 1'b0, 1, cyc + 9);
        push_exp(2, 1'b1, 2, cyc + 14);
        push_exp(3, 1'b1, 4, cyc + 19);
        push_exp(0, 1'b1, 0, cyc + 24);
        wait_done(0);
        wait_done(1);
        wait_done(2);
        wait_done(3);
        wait_done(0);
        req_valid = 4'b0000;

        // Requester 1 sets latch 5: exact phase-by-phase timing.
        wait_idle();
        drive(1, 1'b1, 5);
        push_exp(1, 1'b1, 5, cyc + 4);
        @(negedge clk);
        chk("t2_setup_set",  {31'd0, lat_set},  32'd1);
        chk("t2_setup_clr",  {31'd0, lat_clr},  32'd0);
        chk("t2_setup_gate", {26'd0, lat_gate}, 32'd0);
        chk("t2_setup_busy", {31'd0, busy},     32'd1);
        @(negedge clk);
        chk("t2_gate1", {26'd0, lat_gate}, 32'h20);
        chk("t2_gate1_set", {31'd0, lat_set}, 32'd1);
        @(negedge clk);
        chk("t2_gate2", {26'd0, lat_gate}, 32'h20);
        @(negedge clk);
        chk("t2_rel_gate", {26'd0, lat_gate}, 32'd0);
        chk("t2_rel_done", {28'd0, req_done}, 32'h2);
        chk("t2_rel_set",  {31'd0, lat_set},  32'd1);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t2_idle_set",  {31'd0, lat_set}, 32'd0);
        chk("t2_idle_busy", {31'd0, busy},    32'd0);
        chk("t2_idle_done", {28'd0, req_done}, 32'd0);

        // Set latch 3, then requester 2 clears it while changing its payload mid-sequence.
        single_op(0, 1'b1, 3);
        wait_idle();
        drive(2, 1'b0, 3);
        push_exp(2, 1'b0, 3, cyc + 4);
        @(negedge clk);
        chk("t4_setup_clr", {31'd0, lat_clr}, 32'd1);
        req_op[2]               = 1'b1;
        req_idx[2*IDXW +: IDXW] = 3'd5;
        @(negedge clk);
        chk("t4_gate1", {26'd0, lat_gate}, 32'h08);
        chk("t4_clr",   {31'd0, lat_clr},  32'd1);
        chk("t4_set",   {31'd0, lat_set},  32'd0);
        @(negedge clk);
        chk("t4_gate2", {26'd0, lat_gate}, 32'h08);
        wait_done(2);
        req_valid[2] = 1'b0;

        // Out-of-range index: no gate pulse, idx_err with done.
        single_op(3, 1'b1, 7);

        // Reset during GATE aborts the operation; pointer restarts at requester 0.
        wait_idle();
        drive(1, 1'b1, 2);
        @(negedge clk);
        @(negedge clk);
        chk("t6_gate_before_rst", {26'd0, lat_gate}, 32'h04);
        rst = 1'b1;
        drive(0, 1'b1, 1);
        @(negedge clk);
        chk("t6_gate", {26'd0, lat_gate}, 32'd0);
        chk("t6_set",  {31'd0, lat_set},  32'd0);
        chk("t6_clr",  {31'd0, lat_clr},  32'd0);
        chk("t6_busy", {31'd0, busy},     32'd0);
        chk("t6_done", {28'd0, req_done}, 32'd0);
        chk("t6_shadow", {26'd0, shadow_q}, 32'd0);
        sh_model = 6'b000000;
        @(negedge clk);
        rst = 1'b0;
        push_exp(0, 1'b1, 1, cyc + 4);
        push_exp(1, 1'b1, 2, cyc + 9);
        wait_done(0);
        req_valid[0] = 1'b0;
        wait_done(1);
        req_valid[1] = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
